// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain
//   Generic valid/allowin pipeline backbone with STAGES payload registers.
//   Stage 0 is the youngest (IF), stage STAGES-1 the oldest (WB). Each
//   stage advances when it holds a payload, its ready_go is high and the
//   stage above can take it. A ranged flush squashes stages 0..flush_stage.
//   Occupancy and an input-stall counter are exported for statistics.
//
// Ports
//   clk             rising-edge clock
//   resetn          async active-low reset (release synchronised to clk)
//   in_valid/in_data/in_allowin        producer handshake into stage 0
//   stage_ready_go  per-stage "work finished" from external logic
//   stage_valid     per-stage live flag
//   stage_data      per-stage payload, stage i at [i*DW +: DW]
//   out_valid/out_data/out_ready       consumer handshake from the oldest stage
//   flush/flush_stage                  squash stages 0..flush_stage
//   occupancy       number of live stages
//   stall_cnt       saturating count of cycles with in_valid & ~in_allowin
module pipe_stage_chain #(
   parameter int STAGES = 5,
   parameter int DW     = 64,
   parameter int SW     = 3
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   in_valid,
   input  logic [DW-1:0]          in_data,
   output logic                   in_allowin,
   input  logic [STAGES-1:0]      stage_ready_go,
   output logic [STAGES-1:0]      stage_valid,
   output logic [STAGES*DW-1:0]   stage_data,
   output logic                   out_valid,
   output logic [DW-1:0]          out_data,
   input  logic                   out_ready,
   input  logic                   flush,
   input  logic [SW-1:0]          flush_stage,
   output logic [3:0]             occupancy,
   output logic [31:0]            stall_cnt
);

   localparam logic [SW-1:0] LAST_STAGE = SW'(STAGES - 1);

   // Population count of the live-stage vector.
   function automatic logic [3:0] popcount(input logic [STAGES-1:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int k = 0; k < STAGES; k++) begin
         n = n + {3'd0, v[k]};
      end
      return n;
   endfunction

   logic [1:0]                   rst_sync_q;
   logic                         rst_n_s;
   logic [STAGES-1:0]            valid_q, valid_d;
   logic [STAGES-1:0][DW-1:0]    data_q, data_d;
   logic [STAGES:0]              allowin_s;
   logic [STAGES-1:0]            kill_s, to_next_s, src_valid_s, load_s;
   logic [SW-1:0]                flush_f_s;
   logic [31:0]                  stall_cnt_q, stall_cnt_d;
   logic                         stall_s;

   // Reset synchroniser: assertion is immediate, release waits two clock edges.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_n_s = rst_sync_q[1];

   // Handshake network: flush range, allowin chain, stage-to-stage transfers.
   always_comb begin
      flush_f_s   = flush_stage;
      allowin_s   = '0;
      kill_s      = '0;
      to_next_s   = '0;
      src_valid_s = '0;
      load_s      = '0;
      if (flush_stage > LAST_STAGE) begin
         flush_f_s = LAST_STAGE;
      end else begin
         flush_f_s = flush_stage;
      end
      // Allowin ripples down from the sink towards stage 0.
      allowin_s[STAGES] = out_ready;
      for (int i = STAGES - 1; i >= 0; i--) begin
         allowin_s[i] = ~valid_q[i] | (stage_ready_go[i] & allowin_s[i+1]);
      end
      for (int i = 0; i < STAGES; i++) begin
         kill_s[i]    = flush & (SW'(i) <= flush_f_s);
         // A killed stage never hands its payload upward: the next stage sees a bubble.
         to_next_s[i] = valid_q[i] & stage_ready_go[i] & ~kill_s[i];
      end
      src_valid_s[0] = in_valid & ~flush;
      for (int i = 1; i < STAGES; i++) begin
         src_valid_s[i] = to_next_s[i-1];
      end
      for (int i = 0; i < STAGES; i++) begin
         load_s[i] = src_valid_s[i] & allowin_s[i] & ~kill_s[i];
      end
   end

   // Next-state for stage valid flags and payloads; bubbles leave data untouched.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      for (int i = 0; i < STAGES; i++) begin
         if (kill_s[i]) begin
            valid_d[i] = 1'b0;
         end else if (allowin_s[i]) begin
            valid_d[i] = src_valid_s[i];
         end else begin
            valid_d[i] = valid_q[i];
         end
      end
      if (load_s[0]) begin
         data_d[0] = in_data;
      end else begin
         data_d[0] = data_q[0];
      end
      for (int i = 1; i < STAGES; i++) begin
         if (load_s[i]) begin
            data_d[i] = data_q[i-1];
         end else begin
            data_d[i] = data_q[i];
         end
      end
   end

   // Saturating stall counter next-state; flush cycles count as stalls.
   always_comb begin
      stall_s     = in_valid & ~in_allowin;
      stall_cnt_d = stall_cnt_q;
      if (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Pipeline state registers.
   always_ff @(posedge clk or negedge rst_n_s) begin
      if (!rst_n_s) begin
         valid_q     <= '0;
         data_q      <= '0;
         stall_cnt_q <= 32'd0;
      end else begin
         valid_q     <= valid_d;
         data_q      <= data_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign in_allowin  = allowin_s[0] & ~flush;
   assign out_valid   = valid_q[STAGES-1] & stage_ready_go[STAGES-1] & ~kill_s[STAGES-1];
   assign out_data    = data_q[STAGES-1];
   assign stage_valid = valid_q;
   assign stage_data  = data_q;
   assign occupancy   = popcount(valid_q);
   assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed self-checking bench for pipe_stage_chain (STAGES=5, DW=32).
module tb_pipe_stage_chain;

   localparam int ST = 5;
   localparam int DW = 32;
   localparam int SW = 3;

   logic              clk = 1'b0;
   logic              resetn;
   logic              in_valid;
   logic [DW-1:0]     in_data;
   logic              in_allowin;
   logic [ST-1:0]     stage_ready_go;
   logic [ST-1:0]     stage_valid;
   logic [ST*DW-1:0]  stage_data;
   logic              out_valid;
   logic [DW-1:0]     out_data;
   logic              out_ready;
   logic              flush;
   logic [SW-1:0]     flush_stage;
   logic [3:0]        occupancy;
   logic [31:0]       stall_cnt;

   int checks   = 0;
   int failures = 0;

   pipe_stage_chain #(.STAGES(ST), .DW(DW), .SW(SW)) dut (
      .clk            (clk),
      .resetn         (resetn),
      .in_valid       (in_valid),
      .in_data        (in_data),
      .in_allowin     (in_allowin),
      .stage_ready_go (stage_ready_go),
      .stage_valid    (stage_valid),
      .stage_data     (stage_data),
      .out_valid      (out_valid),
      .out_data       (out_data),
      .out_ready      (out_ready),
      .flush          (flush),
      .flush_stage    (flush_stage),
      .occupancy      (occupancy),
      .stall_cnt      (stall_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] sd(input int i);
      return stage_data[i*DW +: DW];
   endfunction

   task automatic test_reset();
      resetn = 1'b0; in_valid = 1'b0; in_data = 32'd0; stage_ready_go = 5'b11111;
      out_ready = 1'b1; flush = 1'b0; flush_stage = 3'd0;
      #3;
      checks++; if (stage_valid !== 5'b00000) begin failures++; $display("FAIL reset_valid: got %b expected 00000", stage_valid); end
      checks++; if (stage_data !== 160'd0) begin failures++; $display("FAIL reset_data: got %h expected 0", stage_data); end
      checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL reset_stall: got %0d expected 0", stall_cnt); end
      checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (in_allowin !== 1'b1) begin failures++; $display("FAIL reset_allowin: got %b expected 1", in_allowin); end
      tick(); tick();
      resetn = 1'b1;
      tick(); tick(); tick();
   endtask

   task automatic test_fill();
      in_valid = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         in_data = 32'h11 * e;
         tick();
         if (e == 4) begin
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fill_early_out: edge %0d got %b expected 0", e, out_valid); end
            checks++; if (occupancy !== 4'd4) begin failures++; $display("FAIL fill_occ4: got %0d expected 4", occupancy); end
         end
         if (e == 5) begin
            checks++; if (occupancy !== 4'd5) begin failures++; $display("FAIL fill_occ5: got %0d expected 5", occupancy); end
         end
         if (e >= 5) begin
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL fill_out_valid: edge %0d got %b expected 1", e, out_valid); end
            checks++; if (out_data !== 32'h11 * (e - 4)) begin failures++; $display("FAIL fill_out_data: edge %0d got %h expected %h", e, out_data, 32'h11 * (e - 4)); end
         end
      end
   endtask

   task automatic test_ready_go_stall();
      in_data = 32'h88;
      stage_ready_go = 5'b11011;
      #1;
      checks++; if (in_allowin !== 1'b0) begin failures++; $display("FAIL rg_allowin: got %b expected 0", in_allowin); end
      tick();
      checks++; if (stage_valid !== 5'b10111) begin failures++; $display("FAIL rg_bubble: got %b expected 10111", stage_valid); end
      checks++; if (sd(4) !== 32'h44) begin failures++; $display("FAIL rg_st4: got %h expected 44", sd(4)); end
      tick(); tick();
      checks++; if (stage_valid !== 5'b00111) begin failures++; $display("FAIL rg_frozen_valid: got %b expected 00111", stage_valid); end
      checks++; if ({sd(2), sd(1), sd(0)} !== {32'h55, 32'h66, 32'h77}) begin failures++; $display("FAIL rg_frozen_data: got %h %h %h expected 55 66 77", sd(2), sd(1), sd(0)); end
      checks++; if (stall_cnt !== 32'd3) begin failures++; $display("FAIL rg_stall_cnt: got %0d expected 3", stall_cnt); end
      stage_ready_go = 5'b11111;
      tick();
      checks++; if (stage_valid !== 5'b01111) begin failures++; $display("FAIL rg_resume_valid: got %b expected 01111", stage_valid); end
      checks++; if ({sd(3), sd(0)} !== {32'h55, 32'h88}) begin failures++; $display("FAIL rg_resume_data: got %h %h expected 55 88", sd(3), sd(0)); end
      in_data = 32'h99;
      tick();
      checks++; if (stage_valid !== 5'b11111) begin failures++; $display("FAIL rg_full: got %b expected 11111", stage_valid); end
      checks++; if (out_data !== 32'h55) begin failures++; $display("FAIL rg_order: got %h expected 55", out_data); end
   endtask

   task automatic test_backpressure();
      in_data = 32'hAA;
      out_ready = 1'b0;
      #1;
      checks++; if (in_allowin !== 1'b0) begin failures++; $display("FAIL bp_allowin: got %b expected 0", in_allowin); end
      tick(); tick(); tick(); tick();
      checks++; if (stage_valid !== 5'b11111) begin failures++; $display("FAIL bp_valid: got %b expected 11111", stage_valid); end
      checks++; if ({sd(4), sd(3), sd(2), sd(1), sd(0)} !== {32'h55, 32'h66, 32'h77, 32'h88, 32'h99}) begin failures++; $display("FAIL bp_data: got %h expected 55 66 77 88 99", stage_data); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid: got %b expected 1", out_valid); end
      checks++; if (stall_cnt !== 32'd7) begin failures++; $display("FAIL bp_stall_cnt: got %0d expected 7", stall_cnt); end
      out_ready = 1'b1;
      tick();
      checks++; if (out_data !== 32'h66) begin failures++; $display("FAIL bp_order_out: got %h expected 66", out_data); end
      checks++; if (sd(0) !== 32'hAA) begin failures++; $display("FAIL bp_order_in: got %h expected aa", sd(0)); end
      checks++; if (stall_cnt !== 32'd7) begin failures++; $display("FAIL bp_stall_hold: got %0d expected 7", stall_cnt); end
   endtask

   task automatic test_flush();
      in_data = 32'hBB;
      flush = 1'b1;
      flush_stage = 3'd2;
      #1;
      checks++; if (in_allowin !== 1'b0) begin failures++; $display("FAIL fl_allowin: got %b expected 0", in_allowin); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL fl_emit_valid: got %b expected 1", out_valid); end
      checks++; if (out_data !== 32'h66) begin failures++; $display("FAIL fl_emit_data: got %h expected 66", out_data); end
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      checks++; if (stage_valid !== 5'b10000) begin failures++; $display("FAIL fl_valid: got %b expected 10000", stage_valid); end
      checks++; if (occupancy !== 4'd1) begin failures++; $display("FAIL fl_occ: got %0d expected 1", occupancy); end
      checks++; if (sd(4) !== 32'h77) begin failures++; $display("FAIL fl_st4: got %h expected 77", sd(4)); end
      checks++; if (stall_cnt !== 32'd8) begin failures++; $display("FAIL fl_stall_cnt: got %0d expected 8", stall_cnt); end
      flush = 1'b1;
      flush_stage = 3'd7;
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fl_all_out_valid: got %b expected 0", out_valid); end
      tick();
      flush = 1'b0;
      flush_stage = 3'd0;
      checks++; if (stage_valid !== 5'b00000) begin failures++; $display("FAIL fl_all_valid: got %b expected 00000", stage_valid); end
      checks++; if (stall_cnt !== 32'd8) begin failures++; $display("FAIL fl_all_stall: got %0d expected 8", stall_cnt); end
   endtask

   task automatic test_async_reset();
      in_valid = 1'b1;
      for (int e = 1; e <= 3; e++) begin
         in_data = 32'h11 * e;
         tick();
      end
      checks++; if (stage_valid !== 5'b00111) begin failures++; $display("FAIL ar_pre_valid: got %b expected 00111", stage_valid); end
      #2;
      resetn = 1'b0;
      #1;
      checks++; if (stage_valid !== 5'b00000) begin failures++; $display("FAIL ar_valid: got %b expected 00000", stage_valid); end
      checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL ar_stall: got %0d expected 0", stall_cnt); end
      checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL ar_occ: got %0d expected 0", occupancy); end
      tick();
      in_valid = 1'b0;
      resetn = 1'b1;
      tick(); tick(); tick();
      in_valid = 1'b1;
      in_data = 32'h21;
      tick();
      checks++; if (stage_valid !== 5'b00001) begin failures++; $display("FAIL ar_refill_valid: got %b expected 00001", stage_valid); end
      checks++; if (sd(0) !== 32'h21) begin failures++; $display("FAIL ar_refill_data: got %h expected 21", sd(0)); end
   endtask

   task automatic test_saturation();
      out_ready = 1'b0;
      for (int e = 1; e <= 5; e++) begin
         in_data = 32'h21 + e;
         tick();
      end
      checks++; if (stage_valid !== 5'b11111) begin failures++; $display("FAIL sat_full: got %b expected 11111", stage_valid); end
      force dut.stall_cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.stall_cnt_q;
      checks++; if (stall_cnt !== 32'hFFFF_FFFE) begin failures++; $display("FAIL sat_preload: got %h expected fffffffe", stall_cnt); end
      tick();
      checks++; if (stall_cnt !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sat_reach: got %h expected ffffffff", stall_cnt); end
      tick(); tick();
      checks++; if (stall_cnt !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sat_hold: got %h expected ffffffff", stall_cnt); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_ready_go_stall();
      test_backpressure();
      test_flush();
      test_async_reset();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
Parametrised valid/allowin pipeline backbone for the next-generation LoongArch core. It replaces the fixed IF/ID/EXE/MEM/WB sequencing with STAGES generic payload registers. Each stage has its own ready_go, there is a ranged flush from branch/exception resolution, and the block exposes occupancy and stall statistics. Decode, ALU and memory logic sit outside; they read stage payloads and drive ready_go.

Parameters:
STAGES, 5, number of pipeline stages; 2..8; index 0 is youngest (IF), STAGES-1 is oldest (WB).
DW, 64, payload width per stage in bits.
SW, 3, width of flush_stage; must be at least clog2(STAGES).

Ports:
clk  in  1  single clock; all state updates on its rising edge.
resetn  in  1  asynchronous active-low reset: asserting it clears state immediately; deassertion is synchronised to clk.
in_valid  in  1  new payload offered to stage 0.
in_data  in  DW  payload for stage 0.
in_allowin  out  1  stage 0 can accept this cycle.
stage_ready_go  in  STAGES  bit i: stage i has finished its work.
stage_valid  out  STAGES  bit i: stage i holds a live payload.
stage_data  out  STAGES*DW  stage i payload at bits [i*DW +: DW].
out_valid  out  1  oldest stage offers its payload.
out_data  out  DW  equals stage_data of stage STAGES-1.
out_ready  in  1  sink accepts.
flush  in  1  squash request.
flush_stage  in  SW  flush kills stages 0..flush_stage inclusive.
occupancy  out  4  number of valid stages.
stall_cnt  out  32  cycles with in_valid=1 and in_allowin=0.

Behaviour:
- Reset (resetn=0, asynchronous): all stage_valid=0, all stage_data=0, stall_cnt=0. As a consequence occupancy=0, out_valid=0, and in_allowin=1 once flush=0.
- Per stage i:
  - to_next[i] = valid[i] & ready_go[i].
  - allowin[i] = ~valid[i] | (ready_go[i] & allowin[i+1]).
  - allowin[STAGES] = out_ready.
- Source into stage i: src_valid[0] = in_valid; src_valid[i] = to_next[i-1] for i>0.
- Stage i update on each clk edge, no flush: if allowin[i], then valid[i] <= src_valid[i]. Data loads only when src_valid[i] & allowin[i]; otherwise data holds. Bubbles never overwrite data.
- Latency: with all ready_go=1 and out_ready=1, a payload accepted at edge N appears at out_valid after edge N+STAGES-1. Throughput is one per cycle.
- Backpressure is combinational through allowin. Back-to-back transfers are allowed with no bubble.
- Flush (flush=1, f = min(flush_stage, STAGES-1)):
  - valid[k] <= 0 for k<=f. Data is don't-care.
  - to_next[f] is masked, so stage f+1 receives a bubble, not the killed payload.
  - Stages above f+1 advance normally.
  - in_allowin=0 for that cycle and in_data is dropped.
  - flush takes priority over every simultaneous transfer into stages 0..f.
  - f=STAGES-1 empties the pipe and forces out_valid=0 that cycle.
- out_valid = valid[STAGES-1] & ready_go[STAGES-1]. An output transfer occurs when out_valid & out_ready.
- occupancy = popcount(stage_valid), registered-state derived, combinational.
- stall_cnt increments when in_valid & ~in_allowin, including flush cycles. It saturates at 0xFFFFFFFF with no wrap.
- ready_go of an invalid stage is ignored.
- X on inputs is not permitted while resetn=1.

Test Plan:
- STAGES=5, DW=32. Reset, then drive in_valid=1 with data 0x11,0x22,0x33… and all ready_go=1, out_ready=1 -> 0x11 on out_data at the 5th edge; one output per cycle; occupancy=5.
- Steady stream, hold stage_ready_go[2]=0 for 3 cycles -> stages 0–2 frozen with data unchanged; stage 3 shows a bubble; in_allowin=0; stall_cnt rises by 3; the stream resumes with no loss or duplication.
- Full pipe, out_ready=0 for 4 cycles -> every stage_data is held; out_valid stays 1; in_allowin=0; payload order is intact afterwards.
- Full pipe holding A..E (E oldest). Assert flush=1, flush_stage=2 for one cycle -> stages 0–2 invalid; stage 3 shows a bubble; D goes to stage 4; E is emitted; the new in_data is dropped; occupancy=1 next cycle.
- Assert resetn=0 asynchronously mid-stream, between clock edges -> stage_valid=0 and stall_cnt=0 immediately, before the next edge; after release, normal fill restarts.
- Preload stall_cnt near saturation (force 0xFFFFFFFE), then stall 3 cycles -> stall_cnt ends at 0xFFFFFFFF.
